// File: rtl/teachee_input_pkg.sv
// Shared types and 100 MHz sys_clk defaults for TeachEE board input
// conditioning (debounce FSM states, synchronizer depth, timing constants).
package teachee_input_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } debounce_state_t;

    localparam int unsigned SYS_CLK_HZ                = 100_000_000;
    localparam int unsigned DEFAULT_SYNC_STAGES       = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = SYS_CLK_HZ / 100;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = SYS_CLK_HZ;

endpackage

// File: rtl/input_synchronizer.sv
// Flop chain that brings an asynchronous board pin into the sys_clk domain;
// every stage resets to RESET_VAL so no spurious edge follows reset.
module input_synchronizer
    import teachee_input_pkg::*;
#(
    parameter int unsigned STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronizes the raw pin, filters bounce with a
// stability counter and emits a clean level plus press/release/long pulses.
module button_debounce
    import teachee_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic raw_sync;
    logic btn_sync;

    debounce_state_t   state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              held_now;
    logic              held_next;

    // Synchronizer resets to the raw released level for either polarity.
    input_synchronizer #(
        .STAGES   (DEFAULT_SYNC_STAGES),
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk  (sys_clk),
        .reset(reset),
        .d    (button_raw),
        .q    (raw_sync)
    );

    assign btn_sync = raw_sync ^ ACTIVE_LOW;

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;

        held_now = (state_q == PRESSED) || (state_q == RELEASE_CHECK);
        if (held_now && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        unique case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d    = PRESS_CHECK;
                    stab_cnt_d = '0;
                end
            end
            PRESS_CHECK: begin
                if (!btn_sync) begin
                    state_d    = RELEASED;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = PRESSED;
                    stab_cnt_d = '0;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d    = RELEASE_CHECK;
                    stab_cnt_d = '0;
                end
            end
            RELEASE_CHECK: begin
                if (btn_sync) begin
                    state_d    = PRESSED;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = RELEASED;
                    stab_cnt_d = '0;
                    release_d  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = RELEASED;
                stab_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase

        held_next = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
        level_d   = held_next;
        // Suppressed on the release edge so pulses stay mutually exclusive.
        long_d    = held_now && held_next && (hold_cnt_q == HOLD_PRE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= RELEASED;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign button_level     = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule
